rdma_mm2s_cmd_issuer: RTL and testbench

- Sits directly downstream of the SQ-entry AXIS decoder. Consumes its decoded RDMA entry fields and the one-cycle `rdma_entry_valid` pulse.
- Buffers entries in a small FIFO, since the decoder has no backpressure. Converts each entry into an AXI DataMover MM2S command and issues it on an AXIS master.
- Waits for the matching DataMover status, then emits a one-cycle completion record toward the CQ logic.

---
 rtl/rdma_pkg.sv | 43 ++++
 rtl/rdma_entry_fifo.sv | 53 +++++
 rtl/rdma_mm2s_cmd_issuer.sv | 153 +++++++++++++++
 tb/tb_rdma_mm2s_cmd_issuer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_pkg.sv
// Shared definitions for the RDMA MM2S command issuer: completion codes,
// FSM encoding and DataMover command/status bit positions.
package rdma_pkg;

  localparam logic [1:0] CPL_OK      = 2'd0;
  localparam logic [1:0] CPL_LEN_ERR = 2'd1;
  localparam logic [1:0] CPL_DM_ERR  = 2'd2;
  localparam logic [1:0] CPL_TAG_ERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD      = 2'd1,
    ST_WAIT_STS = 2'd2,
    ST_DONE     = 2'd3
  } issuer_state_e;

  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_ADDR_LSB = 32;

  localparam int STS_TAG_LSB    = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

  // A tag mismatch takes priority: a stale status says nothing about this transfer.
  function automatic logic [1:0] sts_to_cpl(input logic [7:0] sts, input logic [3:0] tag);
    logic [1:0] code;
    if (sts[STS_TAG_LSB +: 4] != tag) begin
      code = CPL_TAG_ERR;
    end else if (sts[STS_INTERR_BIT] || sts[STS_DECERR_BIT] || sts[STS_SLVERR_BIT] ||
                 !sts[STS_OKAY_BIT]) begin
      code = CPL_DM_ERR;
    end else begin
      code = CPL_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/rdma_entry_fifo.sv
// Synchronous entry FIFO with occupancy count; a pop frees room for a push
// in the same cycle even when full.
module rdma_entry_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rdma_mm2s_cmd_issuer.sv
// Turns decoded SQ entries into DataMover MM2S commands, one in flight at a
// time, and reports each outcome as a one-cycle completion record.
module rdma_mm2s_cmd_issuer
  import rdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BTT    = 23
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [31:0]             rdma_id,
  input  logic [15:0]             rdma_opcode,
  input  logic [63:0]             rdma_local_key,
  input  logic [127:0]            rdma_btt,
  input  logic                    rdma_entry_valid,
  output logic [ADDR_WIDTH+39:0]  M_AXIS_CMD_TDATA,
  output logic                    M_AXIS_CMD_TVALID,
  input  logic                    M_AXIS_CMD_TREADY,
  input  logic [7:0]              S_AXIS_STS_TDATA,
  input  logic                    S_AXIS_STS_TVALID,
  output logic                    S_AXIS_STS_TREADY,
  output logic                    cpl_valid,
  output logic [31:0]             cpl_id,
  output logic [15:0]             cpl_opcode,
  output logic [1:0]              cpl_status,
  output logic [15:0]             drop_count,
  output logic                    busy
);
  localparam int CMD_W = ADDR_WIDTH + 40;
  localparam int ENT_W = 32 + 16 + ADDR_WIDTH + 32;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  issuer_state_e state_q, state_d;

  logic [ENT_W-1:0]      fifo_din, fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [31:0]           head_id, head_btt;
  logic [15:0]           head_opcode;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  head_len_bad;
  logic [CMD_W-1:0]      cmd_d, cmd_q;
  logic [31:0]           id_q;
  logic [15:0]           opcode_q;
  logic [3:0]            tag_q;
  logic [1:0]            status_q;
  logic [15:0]           drop_count_q;
  logic                  unused_inputs;

  assign fifo_din      = {rdma_id, rdma_opcode, rdma_local_key[ADDR_WIDTH-1:0], rdma_btt[31:0]};
  assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_push     = rdma_entry_valid && (!fifo_full || fifo_pop);
  assign {head_id, head_opcode, head_addr, head_btt} = fifo_dout;
  assign head_len_bad  = (head_btt == 32'd0) || ((head_btt >> MAX_BTT) != 32'd0);
  assign unused_inputs = ^{rdma_local_key, rdma_btt[127:32], fifo_count};

  rdma_entry_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_entry_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The tag is sampled at pop time; it only advances in DONE, so it is the issued tag.
  always_comb begin
    cmd_d = '0;
    cmd_d[MAX_BTT-1:0]                = head_btt[MAX_BTT-1:0];
    cmd_d[CMD_TYPE_BIT]               = 1'b1;
    cmd_d[CMD_DSA_LSB +: 6]           = 6'd0;
    cmd_d[CMD_EOF_BIT]                = 1'b1;
    cmd_d[CMD_DRR_BIT]                = 1'b0;
    cmd_d[CMD_ADDR_LSB +: ADDR_WIDTH] = head_addr;
    cmd_d[CMD_ADDR_LSB+ADDR_WIDTH +: 4] = tag_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = head_len_bad ? ST_DONE : ST_CMD;
        else             state_d = ST_IDLE;
      end
      ST_CMD: begin
        if (M_AXIS_CMD_TREADY) state_d = ST_WAIT_STS;
        else                   state_d = ST_CMD;
      end
      ST_WAIT_STS: begin
        if (S_AXIS_STS_TVALID) state_d = ST_DONE;
        else                   state_d = ST_WAIT_STS;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_CMD_TVALID = 1'b0;
    S_AXIS_STS_TREADY = 1'b0;
    cpl_valid         = 1'b0;
    case (state_q)
      ST_CMD:      M_AXIS_CMD_TVALID = 1'b1;
      ST_WAIT_STS: S_AXIS_STS_TREADY = 1'b1;
      ST_DONE:     cpl_valid         = 1'b1;
      default:     cpl_valid         = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q         <= 32'd0;
      opcode_q     <= 16'd0;
      cmd_q        <= '0;
      tag_q        <= 4'd0;
      status_q     <= CPL_OK;
      drop_count_q <= 16'd0;
    end else begin
      if (fifo_pop) begin
        id_q     <= head_id;
        opcode_q <= head_opcode;
        cmd_q    <= cmd_d;
        status_q <= head_len_bad ? CPL_LEN_ERR : CPL_OK;
      end
      if ((state_q == ST_WAIT_STS) && S_AXIS_STS_TVALID)
        status_q <= sts_to_cpl(S_AXIS_STS_TDATA, tag_q);
      if (state_q == ST_DONE)
        tag_q <= tag_q + 4'd1;
      if (rdma_entry_valid && !fifo_push && (drop_count_q != 16'hFFFF))
        drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign M_AXIS_CMD_TDATA = cmd_q;
  assign cpl_id           = id_q;
  assign cpl_opcode       = opcode_q;
  assign cpl_status       = status_q;
  assign drop_count       = drop_count_q;
  assign busy             = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_rdma_mm2s_cmd_issuer.sv
// Scoreboard bench for rdma_mm2s_cmd_issuer: expected commands and completions
// are queued as entries are driven and checked as the DUT emits them.
module tb_rdma_mm2s_cmd_issuer;
  localparam int AW = 32;
  localparam int CW = AW + 40;

  logic           ACLK = 1'b0;
  logic           ARESET = 1'b1;
  logic [31:0]    rdma_id = 32'd0;
  logic [15:0]    rdma_opcode = 16'd0;
  logic [63:0]    rdma_local_key = 64'd0;
  logic [127:0]   rdma_btt = 128'd0;
  logic           rdma_entry_valid = 1'b0;
  logic [CW-1:0]  M_AXIS_CMD_TDATA;
  logic           M_AXIS_CMD_TVALID;
  logic           M_AXIS_CMD_TREADY = 1'b1;
  logic [7:0]     S_AXIS_STS_TDATA = 8'd0;
  logic           S_AXIS_STS_TVALID = 1'b0;
  logic           S_AXIS_STS_TREADY;
  logic           cpl_valid;
  logic [31:0]    cpl_id;
  logic [15:0]    cpl_opcode;
  logic [1:0]     cpl_status;
  logic [15:0]    drop_count;
  logic           busy;

  rdma_mm2s_cmd_issuer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .MAX_BTT(23)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .rdma_id(rdma_id), .rdma_opcode(rdma_opcode), .rdma_local_key(rdma_local_key),
    .rdma_btt(rdma_btt), .rdma_entry_valid(rdma_entry_valid),
    .M_AXIS_CMD_TDATA(M_AXIS_CMD_TDATA), .M_AXIS_CMD_TVALID(M_AXIS_CMD_TVALID),
    .M_AXIS_CMD_TREADY(M_AXIS_CMD_TREADY),
    .S_AXIS_STS_TDATA(S_AXIS_STS_TDATA), .S_AXIS_STS_TVALID(S_AXIS_STS_TVALID),
    .S_AXIS_STS_TREADY(S_AXIS_STS_TREADY),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_opcode(cpl_opcode),
    .cpl_status(cpl_status), .drop_count(drop_count), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [CW-1:0] tdata; logic [7:0] sts; } cmd_exp_t;
  typedef struct packed { logic [31:0] id; logic [15:0] op; logic [1:0] st; } cpl_exp_t;

  cmd_exp_t  cmd_q[$];
  cpl_exp_t  cpl_q[$];
  logic [7:0] sts_q[$];
  int        total = 0;
  int        bad = 0;
  int        cmd_hs_count = 0;
  logic [3:0] model_tag = 4'd0;
  bit        sts_enable = 1'b1;
  bit        hs_next = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] model_cmd(input logic [31:0] addr, input logic [31:0] btt,
                                              input logic [3:0] tag);
    return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, btt[22:0]};
  endfunction

  function automatic logic [1:0] model_cpl(input logic [7:0] sts, input logic [3:0] tag);
    if (sts[3:0] != tag) return 2'd3;
    if ((sts[6:4] != 3'd0) || !sts[7]) return 2'd2;
    return 2'd0;
  endfunction

  // Drive one entry pulse (caller is just after a rising edge) and queue its expectations.
  task automatic pulse(input logic [31:0] id, input logic [15:0] op, input logic [31:0] addr,
                       input logic [31:0] btt, input logic [3:0] sts_hi, input bit bad_tag,
                       input bit accept);
    cmd_exp_t c;
    cpl_exp_t p;
    logic [7:0] s;
    rdma_id = id; rdma_opcode = op;
    rdma_local_key = {32'h0, addr}; rdma_btt = {96'h0, btt};
    rdma_entry_valid = 1'b1;
    if (accept) begin
      p.id = id; p.op = op;
      if ((btt == 32'd0) || (btt >= 32'h0080_0000)) begin
        p.st = 2'd1;
      end else begin
        s = {sts_hi, bad_tag ? (model_tag ^ 4'h5) : model_tag};
        c.tdata = model_cmd(addr, btt, model_tag);
        c.sts = s;
        cmd_q.push_back(c);
        p.st = model_cpl(s, model_tag);
      end
      cpl_q.push_back(p);
      model_tag = model_tag + 4'd1;
    end
    @(posedge ACLK); #1;
    rdma_entry_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge ACLK); #1; end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || cpl_q.size() != 0 || cmd_q.size() != 0 || sts_q.size() != 0 ||
            S_AXIS_STS_TVALID) && n < 300) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_val(tag, (n < 300), 1);
  endtask

  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    cmd_q.delete(); cpl_q.delete(); sts_q.delete();
    model_tag = 4'd0;
    ARESET = 1'b0;
  endtask

  // Monitor and DataMover status responder share one process to keep queue order deterministic.
  initial begin
    cmd_exp_t c;
    cpl_exp_t p;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        S_AXIS_STS_TVALID = 1'b0;
        hs_next = 1'b0;
      end else begin
        if (hs_next) begin
          check_val("cpl_latency", cpl_valid, 1);
          S_AXIS_STS_TVALID = 1'b0;
          hs_next = 1'b0;
        end
        if (cpl_valid) begin
          if (cpl_q.size() == 0) begin
            check_val("cpl_unexpected", 1, 0);
          end else begin
            p = cpl_q.pop_front();
            check_val("cpl_id", cpl_id, p.id);
            check_val("cpl_opcode", cpl_opcode, p.op);
            check_val("cpl_status", cpl_status, p.st);
          end
        end
        if (!S_AXIS_STS_TVALID && sts_q.size() > 0 && sts_enable) begin
          S_AXIS_STS_TDATA = sts_q.pop_front();
          S_AXIS_STS_TVALID = 1'b1;
        end
        if (S_AXIS_STS_TVALID && S_AXIS_STS_TREADY) hs_next = 1'b1;
        if (M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY) begin
          cmd_hs_count++;
          if (cmd_q.size() == 0) begin
            check_val("cmd_unexpected", 1, 0);
          end else begin
            c = cmd_q.pop_front();
            check_val("cmd_tdata", M_AXIS_CMD_TDATA, c.tdata);
            sts_q.push_back(c.sts);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] exp_cmd;
    int hs_before;
    int n;

    // Reset state
    cycles(2);
    check_val("rst_tvalid", M_AXIS_CMD_TVALID, 0);
    check_val("rst_tdata", M_AXIS_CMD_TDATA, 0);
    check_val("rst_sts_tready", S_AXIS_STS_TREADY, 0);
    check_val("rst_cpl_valid", cpl_valid, 0);
    check_val("rst_cpl_id", cpl_id, 0);
    check_val("rst_cpl_status", cpl_status, 0);
    check_val("rst_drop", drop_count, 0);
    check_val("rst_busy", busy, 0);
    ARESET = 1'b0;

    // Single entry with latency and literal command value
    exp_cmd = {4'h0, 4'h0, 32'h1000_0000, 8'h40, 1'b1, 23'h200};
    pulse(32'h11, 16'h0001, 32'h1000_0000, 32'h200, 4'h8, 1'b0, 1'b1);
    check_val("lat_tvalid_lo", M_AXIS_CMD_TVALID, 0);
    cycles(1);
    check_val("lat_tvalid_hi", M_AXIS_CMD_TVALID, 1);
    check_val("cmd1_literal", M_AXIS_CMD_TDATA, exp_cmd);
    wait_idle("idle_single");

    // Length errors and the largest legal length
    pulse(32'h21, 16'h0002, 32'h2000_0000, 32'h0, 4'h8, 1'b0, 1'b1);
    pulse(32'h22, 16'h0003, 32'h2000_1000, 32'h0080_0000, 4'h8, 1'b0, 1'b1);
    pulse(32'h23, 16'h0004, 32'h2000_2000, 32'h007F_FFFF, 4'h8, 1'b0, 1'b1);
    wait_idle("idle_len");

    // Overflow: TREADY low, 5 accepted (one popped + 4 buffered), 2 dropped
    do_reset();
    M_AXIS_CMD_TREADY = 1'b0;
    for (int i = 0; i < 5; i++)
      pulse(32'h100 + i, 16'h10 + 16'(i), 32'h3000_0000 + 32'(i * 32'h100), 32'h40 + 32'(i), 4'h8, 1'b0, 1'b1);
    check_val("drop_none", drop_count, 0);
    pulse(32'h1F0, 16'h0, 32'h0, 32'h10, 4'h8, 1'b0, 1'b0);
    pulse(32'h1F1, 16'h0, 32'h0, 32'h10, 4'h8, 1'b0, 1'b0);
    check_val("drop_two", drop_count, 2);
    check_val("ovf_tvalid", M_AXIS_CMD_TVALID, 1);
    check_val("ovf_busy", busy, 1);
    M_AXIS_CMD_TREADY = 1'b1;
    wait_idle("idle_ovf");
    check_val("drop_kept", drop_count, 2);

    // DataMover error variants and tag error
    do_reset();
    pulse(32'h200, 16'h20, 32'h4000_0000, 32'h80, 4'hC, 1'b0, 1'b1);
    wait_idle("idle_dm");
    do_reset();
    pulse(32'h201, 16'h21, 32'h4000_1000, 32'h80, 4'h8, 1'b1, 1'b1);
    pulse(32'h202, 16'h22, 32'h4000_2000, 32'h80, 4'h0, 1'b0, 1'b1);
    pulse(32'h203, 16'h23, 32'h4000_3000, 32'h80, 4'h9, 1'b0, 1'b1);
    pulse(32'h204, 16'h24, 32'h4000_4000, 32'h80, 4'hA, 1'b0, 1'b1);
    wait_idle("idle_err");

    // TDATA held while TREADY low for 10 cycles, one handshake only
    M_AXIS_CMD_TREADY = 1'b0;
    hs_before = cmd_hs_count;
    exp_cmd = model_cmd(32'h5555_0000, 32'h1234, model_tag);
    pulse(32'h300, 16'h30, 32'h5555_0000, 32'h1234, 4'h8, 1'b0, 1'b1);
    n = 0;
    while (!M_AXIS_CMD_TVALID && n < 20) begin cycles(1); n++; end
    check_val("hold_tvalid_seen", (n < 20), 1);
    for (int i = 0; i < 10; i++) begin
      check_val("hold_tdata", M_AXIS_CMD_TDATA, exp_cmd);
      check_val("hold_tvalid", M_AXIS_CMD_TVALID, 1);
      cycles(1);
    end
    M_AXIS_CMD_TREADY = 1'b1;
    wait_idle("idle_hold");
    check_val("hold_hs_count", cmd_hs_count - hs_before, 1);

    // Reset while waiting for status
    sts_enable = 1'b0;
    pulse(32'h400, 16'h40, 32'h6000_0000, 32'h99, 4'h8, 1'b0, 1'b1);
    n = 0;
    while (!S_AXIS_STS_TREADY && n < 20) begin cycles(1); n++; end
    check_val("wsts_reached", (n < 20), 1);
    ARESET = 1'b1;
    cycles(1);
    check_val("mrst_tvalid", M_AXIS_CMD_TVALID, 0);
    check_val("mrst_tdata", M_AXIS_CMD_TDATA, 0);
    check_val("mrst_sts_tready", S_AXIS_STS_TREADY, 0);
    check_val("mrst_cpl_valid", cpl_valid, 0);
    check_val("mrst_cpl_id", cpl_id, 0);
    check_val("mrst_busy", busy, 0);
    cmd_q.delete(); cpl_q.delete(); sts_q.delete();
    model_tag = 4'd0;
    ARESET = 1'b0;
    sts_enable = 1'b1;
    cycles(3);
    pulse(32'h401, 16'h41, 32'h6000_1000, 32'h77, 4'h8, 1'b0, 1'b1);
    wait_idle("idle_post_rst");
    check_val("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
